// File: rtl/icosoc_mod_pwmseq.sv
// icosoc_mod_pwmseq: bus-mastering PWM duty sequencer driven from a software-loaded table.
// Define ICOSOC_PWMSEQ_TABLE_RD_EN to make table entries readable over the control bus.
module icosoc_mod_pwmseq #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  output logic        pwm_wr,
  output logic [15:0] pwm_addr,
  output logic [31:0] pwm_wdat,
  input  logic        pwm_done
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  typedef enum logic [2:0] {IDLE, SET_MAX, SET_ON, LOAD, DWELL, STOP} state_t;
  state_t r_state, w_next;
  logic r_run, r_loop;
  logic [31:0] r_period, r_step, r_cnt;
  logic [LW-1:0] r_len;
  logic [IW-1:0] r_idx;
  logic [31:0] r_tab [DEPTH];
  logic w_acc, w_we, w_thit, w_wst, w_ack, w_last;
  logic [13:0] w_toff;
  logic [IW-1:0] w_tidx;
  logic [31:0] w_rtab, w_rval;
  assign w_acc  = (ctrl_wr || ctrl_rd) && !ctrl_done;
  assign w_we   = w_acc && ctrl_wr;
  assign w_toff = ctrl_addr[15:2] - 14'h40;
  assign w_thit = ctrl_addr[15:8] != 8'h0 && w_toff < 14'(DEPTH) && ctrl_addr[1:0] == 2'b00;
  assign w_tidx = w_toff[IW-1:0];
  assign w_wst  = r_state inside {SET_MAX, SET_ON, LOAD};
  assign w_ack  = pwm_wr && pwm_done;
  assign w_last = LW'(r_idx) + LW'(1) >= r_len;
`ifdef ICOSOC_PWMSEQ_TABLE_RD_EN
  assign w_rtab = r_tab[w_tidx];
`else
  assign w_rtab = 32'h0;
`endif
  assign w_rval = ctrl_addr == 16'h0000 ? {30'h0, r_loop, r_run}
                : ctrl_addr == 16'h0004 ? r_period
                : ctrl_addr == 16'h0008 ? r_step
                : ctrl_addr == 16'h000c ? 32'(r_len)
                : ctrl_addr == 16'h0010 ? {16'h0, 8'(r_idx), 7'h0, r_state != IDLE}
                : w_thit ? w_rtab : 32'h0;
  // An issued PWM write is always allowed to finish before an abort takes effect
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = r_run && r_len != '0 ? SET_MAX : IDLE;
      SET_MAX, SET_ON, LOAD:
        if (!r_run && (!pwm_wr || pwm_done)) w_next = IDLE;
        else if (w_ack) w_next = r_state == SET_MAX ? SET_ON : r_state == SET_ON ? LOAD : DWELL;
      DWELL:
        if (!r_run) w_next = IDLE;
        else if (r_cnt == 32'h0) w_next = !w_last || (r_loop && r_len != '0) ? LOAD : STOP;
      STOP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  // Entering a write state with pwm_wr low gives the mandatory idle gap before the request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_wr   <= 1'b0;
      pwm_addr <= 16'h0;
      pwm_wdat <= 32'h0;
      r_idx    <= '0;
      r_cnt    <= 32'h0;
    end else if (r_state == IDLE && w_next == SET_MAX) begin
      pwm_wr   <= 1'b1;
      pwm_addr <= 16'h0004;
      pwm_wdat <= r_period;
      r_idx    <= '0;
    end else if (w_wst && w_ack) begin
      pwm_wr <= 1'b0;
      r_cnt  <= r_step == 32'h0 ? 32'h0 : r_step - 32'h1;
    end else if (w_wst && !pwm_wr && r_run) begin
      pwm_wr   <= 1'b1;
      pwm_addr <= r_state == SET_ON ? 16'h0008 : 16'h000c;
      pwm_wdat <= r_state == SET_ON ? 32'h0 : r_tab[r_idx];
    end else if (r_state == DWELL) begin
      r_cnt <= r_cnt - 32'(r_cnt != 32'h0);
      if (w_next == LOAD) r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_done <= 1'b0;
      ctrl_rdat <= 32'h0;
      r_run     <= 1'b0;
      r_loop    <= 1'b0;
      r_period  <= 32'h0;
      r_step    <= 32'h0;
      r_len     <= '0;
    end else begin
      ctrl_done <= w_acc;
      ctrl_rdat <= w_acc && ctrl_rd ? w_rval : 32'h0;
      if (r_state == STOP) r_run <= 1'b0;
      if (w_we && ctrl_addr == 16'h0000) begin
        r_run  <= ctrl_wdat[0] && r_len != '0;
        r_loop <= ctrl_wdat[1];
      end
      if (w_we && ctrl_addr == 16'h0004) r_period <= ctrl_wdat;
      if (w_we && ctrl_addr == 16'h0008) r_step <= ctrl_wdat;
      if (w_we && ctrl_addr == 16'h000c) r_len <= ctrl_wdat > 32'(DEPTH) ? LW'(DEPTH) : LW'(ctrl_wdat);
    end
  end
  always_ff @(posedge clk)
    if (w_we && w_thit) r_tab[w_tidx] <= ctrl_wdat;
endmodule
